// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loaders.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         HDR_BYTES         = 2;

  // The loader accepts bytes everywhere except in its two terminal states.
  function automatic logic state_ready(state_e s);
    return !((s == DONE) || (s == ERROR));
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Shifts bytes into a big-endian 32-bit word and pulses word_ready_o the
// cycle after the fourth byte of a word has been taken.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  byte_idx_o,
  output logic        word_ready_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= 32'd0;
      idx_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (clear_i) begin
        word_q <= 32'd0;
        idx_q  <= 2'd0;
      end else if (byte_valid_i) begin
        word_q  <= {word_q[23:0], byte_i};
        idx_q   <= idx_q + 2'd1;
        ready_q <= (idx_q == 2'd3);
      end
    end
  end

  assign word_o       = word_q;
  assign byte_idx_o   = idx_q;
  assign word_ready_o = ready_q;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a sync/length/data/checksum frame, writes instruction
// memory word by word and releases the CPU once the checksum matches.
module instr_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          LEN_W     = 8 * HDR_BYTES;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1 << ADDR_W);

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [7:0]         checksum_q;
  logic [ADDR_W:0]    words_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               cpu_run_q;
  logic               load_err_q;

  logic               accept;
  logic               data_accept;
  logic               sync_seen;
  logic               asm_clear;
  logic [1:0]         byte_idx;
  logic [LEN_W-1:0]   len_next;
  logic               len_bad;
  logic [ADDR_W:0]    words_inc;
  logic               last_word;

  // reload wins over a byte offered in the same cycle
  assign rx_ready    = state_ready(state_q);
  assign accept      = rx_valid & rx_ready & ~reload;
  assign data_accept = accept & (state_q == DATA);
  assign sync_seen   = accept & (state_q == IDLE) & (rx_data == SYNC_BYTE);
  assign asm_clear   = reload | sync_seen;

  assign len_next  = {len_q[LEN_W-9:0], rx_data};
  assign len_bad   = (len_next == '0) || ({1'b0, len_next} > MAX_WORDS);
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = ({{(LEN_W-ADDR_W-1){1'b0}}, words_inc} == len_q);

  word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .byte_valid_i (data_accept),
    .byte_i       (rx_data),
    .word_o       (im_wdata),
    .byte_idx_o   (byte_idx),
    .word_ready_o (im_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      checksum_q <= 8'd0;
      words_q    <= '0;
      addr_q     <= '0;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else if (reload) begin
      state_q   <= IDLE;
      cpu_run_q <= 1'b0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_q    <= LEN_HI;
            words_q    <= '0;
            checksum_q <= 8'd0;
            load_err_q <= 1'b0;
          end
        end
        LEN_HI: begin
          len_q   <= len_next;
          state_q <= LEN_LO;
        end
        LEN_LO: begin
          len_q <= len_next;
          if (len_bad) begin
            state_q    <= ERROR;
            load_err_q <= 1'b1;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: begin
          checksum_q <= checksum_q ^ rx_data;
          // address is the pre-increment count, so it lines up with im_we
          if (byte_idx == 2'd3) begin
            addr_q  <= words_q[ADDR_W-1:0];
            words_q <= words_inc;
            if (last_word) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (rx_data == checksum_q) begin
            state_q   <= DONE;
            cpu_run_q <= 1'b1;
          end else begin
            state_q    <= ERROR;
            load_err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign im_addr      = addr_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule
